ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 15 +
 rtl/ram_arbiter_if.sv | 23 ++
 rtl/rr_pick2.sv | 20 ++
 rtl/ram_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
package ram_arb_pkg;

    // Default RAM geometry: 128 entries of 8 bits.
    localparam int RAM_AW = 7;
    localparam int RAM_DW = 8;

    // Arbiter FSM encoding.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side port of the RAM arbiter.
//
// Handshake: the master raises req together with we/addr/wdata and holds
// all of them steady until it sees ack. ack is a single-cycle pulse; rdata
// is valid in the ack cycle of a read and is held until that requester's
// next read completes. A req still high in the ack cycle counts as a new
// request.
interface ram_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int AW = RAM_AW,
    parameter int DW = RAM_DW
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: a lone request wins outright,
// a tie goes to the requester named by prio.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic prio,
    output logic gnt_id
);

    // Choose the winner id from the current requests and priority pointer.
    always_comb begin
        gnt_id = 1'b0;
        if (req0 && req1) begin
            gnt_id = prio;
        end else if (req1) begin
            gnt_id = 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto a single-ported RAM with a shared
// bidirectional data bus. Each access takes IDLE -> ACCESS -> RESP; all
// RAM strobes and acks come straight from flops.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW = RAM_AW,
    parameter int DW = RAM_DW
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  p0,
    ram_arbiter_if.slave  p1,
    output logic          cs1,
    output logic          cs2,
    output logic          rd,
    output logic          wr,
    output logic [AW-1:0] addr,
    inout  wire  [DW-1:0] mag,
    output logic          mag_oe,
    output state_e        state_dbg
);

    state_e        state_q, state_d;
    logic          prio_q, prio_d;
    logic          id_q, id_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          cs1_q, cs1_d;
    logic          cs2_q, cs2_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          mag_oe_q, mag_oe_d;

    logic          gnt_id;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    rr_pick2 u_pick (
        .req0   (p0.req),
        .req1   (p1.req),
        .prio   (prio_q),
        .gnt_id (gnt_id)
    );

    assign sel_we    = gnt_id ? p1.we    : p0.we;
    assign sel_addr  = gnt_id ? p1.addr  : p0.addr;
    assign sel_wdata = gnt_id ? p1.wdata : p0.wdata;

    // Next-state logic: RAM strobes are computed one cycle ahead so that
    // they are registered for the whole ACCESS cycle and idle elsewhere.
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        id_d     = id_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        cs1_d    = 1'b0;
        cs2_d    = 1'b1;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        addr_d   = '0;
        mag_oe_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (p0.req || p1.req) begin
                    state_d  = ACCESS;
                    id_d     = gnt_id;
                    prio_d   = ~gnt_id;
                    we_d     = sel_we;
                    wdata_d  = sel_wdata;
                    cs1_d    = 1'b1;
                    cs2_d    = 1'b0;
                    wr_d     = sel_we;
                    rd_d     = ~sel_we;
                    addr_d   = sel_addr;
                    mag_oe_d = sel_we;
                end
            end
            ACCESS: begin
                state_d = RESP;
                // The RAM presents read data during ACCESS; capture it at
                // the edge that ends the cycle.
                if (!we_q) begin
                    if (id_q) begin
                        rdata1_d = mag;
                    end else begin
                        rdata0_d = mag;
                    end
                end
                if (id_q) begin
                    ack1_d = 1'b1;
                end else begin
                    ack0_d = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            id_q     <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            cs1_q    <= 1'b0;
            cs2_q    <= 1'b1;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            mag_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            id_q     <= id_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            cs1_q    <= cs1_d;
            cs2_q    <= cs2_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            mag_oe_q <= mag_oe_d;
        end
    end

    // A reset arriving during RESP must swallow the pending ack.
    assign p0.ack    = ack0_q & ~rst;
    assign p1.ack    = ack1_q & ~rst;
    assign p0.rdata  = rdata0_q;
    assign p1.rdata  = rdata1_q;

    assign cs1       = cs1_q;
    assign cs2       = cs2_q;
    assign rd        = rd_q;
    assign wr        = wr_q;
    assign addr      = addr_q;
    assign mag_oe    = mag_oe_q;
    assign mag       = mag_oe_q ? wdata_q : {DW{1'bz}};
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural RAM on the bus.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int AW = 7;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    ram_arbiter_if #(.AW(AW), .DW(DW)) p0 ();
    ram_arbiter_if #(.AW(AW), .DW(DW)) p1 ();
    logic          cs1, cs2, rd, wr, mag_oe;
    logic [AW-1:0] addr;
    wire  [DW-1:0] mag;
    state_e        state_dbg;

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .p0        (p0),
        .p1        (p1),
        .cs1       (cs1),
        .cs2       (cs2),
        .rd        (rd),
        .wr        (wr),
        .addr      (addr),
        .mag       (mag),
        .mag_oe    (mag_oe),
        .state_dbg (state_dbg)
    );

    // Behavioural RAM: asynchronous read onto the bus, write at posedge.
    logic [DW-1:0] ram_mem [128] = '{default: 8'h00};
    assign mag = (cs1 && !cs2 && rd) ? ram_mem[addr] : {DW{1'bz}};
    always @(posedge clk) begin
        if (cs1 && !cs2 && wr) ram_mem[addr] <= mag;
    end

    a_rd_wr: assert property (@(posedge clk) !(rd && wr))
        else $error("FAIL assert_rd_wr: rd and wr both high");
    a_rd_drive: assert property (@(posedge clk) !(rd && mag_oe))
        else $error("FAIL assert_rd_drive: arbiter drives mag during rd");

    // ---------------- reference model + scoreboard ----------------
    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] ref_mem [128] = '{default: 8'h00};
    logic [DW-1:0] ref_rd  [2]   = '{8'h00, 8'h00};
    logic [DW-1:0] mon_rd  [2]   = '{8'h00, 8'h00};
    // entry = {we, addr, wdata, expected rdata}
    logic [23:0]   exp0_q [$];
    logic [23:0]   exp1_q [$];
    int            ack_id_log  [$];
    int            ack_cyc_log [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a write leaves the requester's rdata alone, a read returns memory.
    task automatic expect_txn(input int id, input logic we, input logic [6:0] a, input logic [7:0] d);
        logic [7:0] e;
        if (we) begin
            ref_mem[a] = d;
            e = ref_rd[id];
        end else begin
            e = ref_mem[a];
            ref_rd[id] = e;
        end
        if (id == 0) exp0_q.push_back({we, a, d, e});
        else         exp1_q.push_back({we, a, d, e});
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int id, input logic r, input logic we, input logic [6:0] a, input logic [7:0] d);
        if (id == 0) begin
            p0.req = r; p0.we = we; p0.addr = a; p0.wdata = d;
        end else begin
            p1.req = r; p1.we = we; p1.addr = a; p1.wdata = d;
        end
    endtask

    // Called just after a posedge; returns cycles from request to ack.
    task automatic issue(input int id, input logic we, input logic [6:0] a, input logic [7:0] d, output int lat);
        int start;
        expect_txn(id, we, a, d);
        start = cyc;
        lat = -1;
        set_req(id, 1'b1, we, a, d);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((id == 0) ? p0.ack : p1.ack) begin
                lat = cyc - start;
                break;
            end
        end
        if (lat < 0) begin
            total++;
            bad++;
            $display("FAIL ack_timeout%0d: got no ack in 20 cycles, want ack", id);
        end
        @(posedge clk); #1;
        set_req(id, 1'b0, we, a, d);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 7'd0, 8'd0);
        set_req(1, 1'b0, 1'b0, 7'd0, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ref_rd[0] = 8'h00;
        ref_rd[1] = 8'h00;
    endtask

    // ---------------- monitor ----------------
    logic          p_cs1, p_cs2, p_rd, p_wr, p_oe;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_mag;

    task automatic mon_pop(input int id);
        logic [23:0] e;
        logic        we;
        logic [6:0]  a;
        logic [7:0]  d, r;
        if ((id == 0 && exp0_q.size() == 0) || (id == 1 && exp1_q.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack%0d: got ack with nothing pending, want no ack", id);
            return;
        end
        e = (id == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
        {we, a, d, r} = e;
        check("acc_cs", 32'({p_cs1, p_cs2}), 32'd2);
        check("acc_wr", 32'(p_wr), 32'(we));
        check("acc_rd", 32'(p_rd), 32'(!we));
        check("acc_addr", 32'(p_addr), 32'(a));
        if (we) check("acc_wdata", 32'(p_mag), 32'(d));
        else    check("acc_hiz", 32'(p_oe), 32'd0);
        mon_rd[id] = r;
        ack_id_log.push_back(id);
        ack_cyc_log.push_back(cyc);
    endtask

    // Compare every cycle, popping the expected queue on each ack.
    always @(negedge clk) begin
        if (rst) begin
            mon_rd[0] = 8'h00;
            mon_rd[1] = 8'h00;
        end else begin
            check("rd_wr_excl", 32'(rd & wr), 32'd0);
            check("rd_drive", 32'(rd & mag_oe), 32'd0);
            check("ack_onehot", 32'(p0.ack & p1.ack), 32'd0);
            if (!cs1) check("ram_idle", 32'({cs2, rd, wr, mag_oe, addr}), 32'(11'b100_0000_0000));
            if (p0.ack) mon_pop(0);
            if (p1.ack) mon_pop(1);
            check("rdata0", 32'(p0.rdata), 32'(mon_rd[0]));
            check("rdata1", 32'(p1.rdata), 32'(mon_rd[1]));
        end
        p_cs1 = cs1; p_cs2 = cs2; p_rd = rd; p_wr = wr; p_oe = mag_oe;
        p_addr = addr; p_mag = mag;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got no end of test, want finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int c0;
        set_req(0, 1'b0, 1'b0, 7'd0, 8'd0);
        set_req(1, 1'b0, 1'b0, 7'd0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        check("rst_ack", 32'({p0.ack, p1.ack}), 32'd0);
        check("rst_rdata0", 32'(p0.rdata), 32'd0);
        check("rst_rdata1", 32'(p1.rdata), 32'd0);
        check("rst_ram", 32'({cs1, cs2, rd, wr, mag_oe, addr}), 32'(12'b0100_0000_0000));

        // Directed write / read sequences with exact latency.
        issue(0, 1'b1, 7'd10, 8'd170, lat);
        check("lat_w0", 32'(lat), 32'd2);
        issue(1, 1'b1, 7'd20, 8'd255, lat);
        check("lat_w1", 32'(lat), 32'd2);
        issue(1, 1'b0, 7'd20, 8'd0, lat);
        check("lat_r1", 32'(lat), 32'd2);
        issue(0, 1'b0, 7'd10, 8'd0, lat);
        check("lat_r0", 32'(lat), 32'd2);

        // Both held high after reset: grants alternate starting with 0.
        do_reset();
        ack_id_log.delete();
        ack_cyc_log.delete();
        for (int i = 0; i < 4; i++) begin
            expect_txn(0, 1'b0, 7'd10, 8'd0);
            expect_txn(1, 1'b0, 7'd20, 8'd0);
        end
        c0 = cyc;
        set_req(0, 1'b1, 1'b0, 7'd10, 8'd0);
        set_req(1, 1'b1, 1'b0, 7'd20, 8'd0);
        for (int i = 0; i < 60 && ack_id_log.size() < 8; i++) @(posedge clk);
        #1;
        set_req(0, 1'b0, 1'b0, 7'd0, 8'd0);
        set_req(1, 1'b0, 1'b0, 7'd0, 8'd0);
        check("alt_count", 32'(ack_id_log.size()), 32'd8);
        for (int i = 0; i < ack_id_log.size(); i++) begin
            check("alt_id", 32'(ack_id_log[i]), 32'(i % 2));
            check("alt_cycle", 32'(ack_cyc_log[i]), 32'(c0 + 2 + 3 * i));
        end

        // Reset in the RESP cycle of a read: the ack never shows.
        set_req(1, 1'b1, 1'b0, 7'd20, 8'd0);
        @(posedge clk); #1;
        set_req(1, 1'b0, 1'b0, 7'd0, 8'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("resp_rst_ack", 32'(p1.ack), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ref_rd[0] = 8'h00;
        ref_rd[1] = 8'h00;
        check("resp_rst_state", 32'(state_dbg), 32'(IDLE));

        // Reset in the ACCESS cycle of a write: the write still lands.
        set_req(0, 1'b1, 1'b1, 7'd5, 8'd60);
        ref_mem[5] = 8'd60;
        @(posedge clk); #1;
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 7'd0, 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ref_rd[0] = 8'h00;
        ref_rd[1] = 8'h00;
        check("abort_state", 32'(state_dbg), 32'(IDLE));
        check("abort_rdata0", 32'(p0.rdata), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        issue(1, 1'b0, 7'd5, 8'd0, lat);
        check("lat_abort_r1", 32'(lat), 32'd2);
        issue(0, 1'b0, 7'd5, 8'd0, lat);
        check("lat_abort_r0", 32'(lat), 32'd2);

        // Random concurrent traffic in disjoint address halves.
        fork
            begin : rand0
                int l0;
                int g0;
                for (int n = 0; n < 25; n++) begin
                    g0 = int'($urandom_range(0, 3));
                    if (g0 > 0) begin
                        repeat (g0) @(posedge clk);
                        #1;
                    end
                    issue(0, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 63)),
                          8'($urandom_range(0, 255)), l0);
                    check("rand_lat0", 32'(l0 >= 2 && l0 <= 5), 32'd1);
                end
            end
            begin : rand1
                int l1;
                int g1;
                for (int n = 0; n < 25; n++) begin
                    g1 = int'($urandom_range(0, 3));
                    if (g1 > 0) begin
                        repeat (g1) @(posedge clk);
                        #1;
                    end
                    issue(1, 1'($urandom_range(0, 1)), 7'($urandom_range(64, 127)),
                          8'($urandom_range(0, 255)), l1);
                    check("rand_lat1", 32'(l1 >= 2 && l1 <= 5), 32'd1);
                end
            end
        join

        repeat (5) @(posedge clk);
        #1;
        check("drain0", 32'(exp0_q.size()), 32'd0);
        check("drain1", 32'(exp1_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
